sd_cmd_seq: RTL

SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

---
 rtl/sd_cmd_seq.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq -- SD command sequencer.
//
// Sends one SD command frame through a register-mapped SD line peripheral and,
// unless the command is flagged no-response, bit-bangs the 48-bit response back
// in by toggling the peripheral clock and sampling the cmd line.
//
// Configuration macro: SD_CMD_SEQ_CRC_EN
//   defined   -> the last frame byte carries a real CRC-7 over bytes 0..4
//   undefined -> the CRC field is zero (last byte 8'h01) and no CRC logic exists
//
// Ports
//   i_clock, i_reset           clock, synchronous active-high reset
//   CPU slave port             i_request, i_rw (1=write), i_address[1:0],
//                              i_wdata[31:0], o_rdata[31:0], o_ready
//     write addr0 = argument, addr1 = start {[6]=no_resp, [5:0]=cmd index}
//     read  addr0 = status {end_err, done, timeout, busy}, addr1 = resp[39:8],
//           addr2 = resp[47:40], addr3 = resp[7:0]
//   SD master port             o_sd_request, o_sd_rw, o_sd_address[1:0],
//                              o_sd_wdata[31:0], i_sd_rdata[31:0], i_sd_ready
`timescale 1ns/1ps
module sd_cmd_seq (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [1:0]  i_address,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_sd_request,
   output logic        o_sd_rw,
   output logic [1:0]  o_sd_address,
   output logic [31:0] o_sd_wdata,
   input  logic [31:0] i_sd_rdata,
   input  logic        i_sd_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_RX_DIR,
      S_RX_LO,
      S_RX_SAMPLE,
      S_RX_HI,
      S_DONE
   } state_t;

   state_t      state;
   logic        releasing;
   logic [31:0] arg;
   logic [5:0]  cmd_index;
   logic        no_resp;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        end_err;
   logic [47:0] resp;
   logic [47:0] rx_shift;
   logic [2:0]  byte_cnt;
   logic [6:0]  search_cnt;
   logic [5:0]  bit_cnt;
   logic        started;
   logic        sample_bit;
   logic        rx_tmo;
   logic        rx_last;
   logic [6:0]  crc7;
   logic [7:0]  frame_byte;
   logic        issue_rw;
   logic [1:0]  issue_addr;
   logic [31:0] issue_wdata;
   logic        cpu_access;
   logic        unused_sd_rdata;

   // Only the cmd line bit of the peripheral read data matters here.
   assign unused_sd_rdata = ^{i_sd_rdata[31:4], i_sd_rdata[2:0]};

`ifdef SD_CMD_SEQ_CRC_EN
   // CRC-7 (x^7 + x^3 + 1, init 0) over the 40 bits of bytes 0..4, MSB first.
   // Index and argument are frozen while busy, so the value is settled long
   // before the last byte is issued.
   function automatic logic [6:0] crc7_calc(input logic [39:0] data);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = data[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign crc7 = crc7_calc({2'b01, cmd_index, arg});
`else
   assign crc7 = 7'h00;
`endif

   // Byte of the command frame selected by the send counter.
   always_comb begin
      frame_byte = {crc7, 1'b1};
      case (byte_cnt)
         3'd0:    frame_byte = {2'b01, cmd_index};
         3'd1:    frame_byte = arg[31:24];
         3'd2:    frame_byte = arg[23:16];
         3'd3:    frame_byte = arg[15:8];
         3'd4:    frame_byte = arg[7:0];
         default: frame_byte = {crc7, 1'b1};
      endcase
   end

   // Peripheral access that the current state wants to make.
   always_comb begin
      issue_rw    = 1'b0;
      issue_addr  = 2'd0;
      issue_wdata = 32'h0;
      case (state)
         S_SEND: begin
            issue_rw    = 1'b1;
            issue_addr  = 2'd1;
            issue_wdata = {24'h0, frame_byte};
         end
         S_RX_DIR: begin
            issue_rw    = 1'b1;
            issue_wdata = 32'h0000_0200;
         end
         S_RX_LO: begin
            issue_rw    = 1'b1;
            issue_wdata = 32'h0000_0100;
         end
         S_RX_HI: begin
            issue_rw    = 1'b1;
            issue_wdata = 32'h0000_0101;
         end
         default: begin
            issue_rw    = 1'b0;
            issue_wdata = 32'h0;
         end
      endcase
   end

   // A CPU access is acted on once, in the cycle its request is first seen.
   assign cpu_access = i_request & ~o_ready;

   // Sequencer, peripheral handshake and CPU register file.
   // Each peripheral transaction runs in two phases: issue (request held until
   // ready rises, data latched) and release (request low until ready falls).
   // A new request is only raised while ready is low, so a peripheral still
   // finishing an earlier transaction (e.g. after a reset) is never confused.
   // The CPU section sits last so a start accepted during DONE wins over the
   // DONE -> IDLE transition.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= S_IDLE;
         releasing    <= 1'b0;
         arg          <= 32'h0;
         cmd_index    <= 6'h0;
         no_resp      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         end_err      <= 1'b0;
         resp         <= 48'h0;
         rx_shift     <= 48'h0;
         byte_cnt     <= 3'd0;
         search_cnt   <= 7'd0;
         bit_cnt      <= 6'd0;
         started      <= 1'b0;
         sample_bit   <= 1'b0;
         rx_tmo       <= 1'b0;
         rx_last      <= 1'b0;
         o_rdata      <= 32'h0;
         o_ready      <= 1'b0;
         o_sd_request <= 1'b0;
         o_sd_rw      <= 1'b0;
         o_sd_address <= 2'd0;
         o_sd_wdata   <= 32'h0;
      end else begin
         o_ready <= i_request;

         case (state)
            S_IDLE: ;
            S_DONE: state <= S_IDLE;
            default: begin
               if (!releasing) begin
                  if (!o_sd_request) begin
                     if (!i_sd_ready) begin
                        o_sd_request <= 1'b1;
                        o_sd_rw      <= issue_rw;
                        o_sd_address <= issue_addr;
                        o_sd_wdata   <= issue_wdata;
                     end
                  end else if (i_sd_ready) begin
                     o_sd_request <= 1'b0;
                     releasing    <= 1'b1;
                     if (state == S_RX_SAMPLE) sample_bit <= i_sd_rdata[3];
                  end
               end else if (!i_sd_ready) begin
                  releasing <= 1'b0;
                  case (state)
                     S_SEND: begin
                        if (byte_cnt == 3'd5) begin
                           byte_cnt <= 3'd0;
                           if (no_resp) begin
                              busy  <= 1'b0;
                              done  <= 1'b1;
                              state <= S_DONE;
                           end else begin
                              state <= S_RX_DIR;
                           end
                        end else begin
                           byte_cnt <= byte_cnt + 3'd1;
                        end
                     end
                     S_RX_DIR: state <= S_RX_LO;
                     S_RX_LO:  state <= S_RX_SAMPLE;
                     S_RX_SAMPLE: begin
                        state <= S_RX_HI;
                        if (started) begin
                           rx_shift <= {rx_shift[46:0], sample_bit};
                           bit_cnt  <= bit_cnt + 6'd1;
                           if (bit_cnt == 6'd47) rx_last <= 1'b1;
                        end else if (!sample_bit) begin
                           started  <= 1'b1;
                           rx_shift <= {rx_shift[46:0], 1'b0};
                           bit_cnt  <= 6'd1;
                        end else begin
                           search_cnt <= search_cnt + 7'd1;
                           if (search_cnt == 7'd63) rx_tmo <= 1'b1;
                        end
                     end
                     S_RX_HI: begin
                        if (rx_tmo) begin
                           timeout <= 1'b1;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           state   <= S_DONE;
                        end else if (rx_last) begin
                           resp    <= rx_shift;
                           end_err <= ~rx_shift[0];
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           state   <= S_DONE;
                        end else begin
                           state <= S_RX_LO;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase

         if (cpu_access) begin
            if (i_rw) begin
               if (!busy) begin
                  case (i_address)
                     2'd0: arg <= i_wdata;
                     2'd1: begin
                        cmd_index  <= i_wdata[5:0];
                        no_resp    <= i_wdata[6];
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        end_err    <= 1'b0;
                        state      <= S_SEND;
                        releasing  <= 1'b0;
                        byte_cnt   <= 3'd0;
                        search_cnt <= 7'd0;
                        bit_cnt    <= 6'd0;
                        started    <= 1'b0;
                        rx_tmo     <= 1'b0;
                        rx_last    <= 1'b0;
                        rx_shift   <= 48'h0;
                     end
                     default: ;
                  endcase
               end
            end else begin
               case (i_address)
                  2'd0:    o_rdata <= {28'h0, end_err, done, timeout, busy};
                  2'd1:    o_rdata <= resp[39:8];
                  2'd2:    o_rdata <= {24'h0, resp[47:40]};
                  default: o_rdata <= {24'h0, resp[7:0]};
               endcase
            end
         end
      end
   end

endmodule
